keypad_multitap: RTL and testbench
==================================

Name: keypad_multitap

Overview:
- Parametrised multi-tap keypad letter encoder. Successor to the single-shot keypad FSM.
- Converts debounced 4x4 keypad presses into committed ASCII letters using phone-style multi-tap.
- Adds timeout auto-commit, commit-on-new-key, wrap/saturate mode, lowercase mode, backspace and a live preview.
- Sits between the keypad scanner/strobe generator and the hangman message/transmit logic.

Parameters:
- TIMEOUT_CYCLES, 12_000_000: idle cycles in PEND before the pending letter auto-commits; must be >= 2. Counter width is a derived localparam, $clog2(TIMEOUT_CYCLES+1).
- WRAP, 1: 1 = tap past last letter of group returns to first; 0 = saturates at last letter.
- LOWERCASE, 0: 1 = emit 'a'-'z' (uppercase code + 32); 0 = 'A'-'Z'.

Ports:
- clk  in  1  system clock.
- nRst  in  1  asynchronous active-low reset.
- strobe  in  1  one-cycle pulse on key press edge.
- cur_key  in  8  {row[3:0], col[3:0]}, one-hot each; bit7 = R0, bit3 = C0.
- ready  out  1  one-cycle pulse: data holds a newly committed letter.
- data  out  8  last committed ASCII letter.
- preview  out  8  ASCII of the pending letter; 0 when none.
- pending  out  1  high while a letter is pending (state PEND).
- tap_count  out  2  index of the pending letter within its group.
- toggle_state  out  1  one-cycle pulse: word submitted.
- game_end  out  1  one-cycle pulse: game end key pressed.
- backspace  out  1  one-cycle pulse: delete previously committed letter.

Behaviour:
- All outputs are registered. Reset state is IDLE with every output 0 and the timer at 0.
- A key event is strobe=1 with cur_key in the map below. All other cur_key values (0, multi-hot, keys 1/A/B) are ignored with no state change. cur_key without strobe is ignored.
- Every response appears on the edge after the event cycle (1-cycle latency). Pulses last exactly one cycle.
- Letter keys and groups:
  - 2 = 8'h84, ABC
  - 3 = 8'h82, DEF
  - 4 = 8'h48, GHI
  - 5 = 8'h44, JKL
  - 6 = 8'h42, MNO
  - 7 = 8'h28, PQRS
  - 8 = 8'h24, TUV
  - 9 = 8'h22, WXYZ
- Control keys:
  - * = 8'h18, commit letter
  - 0 = 8'h14, clear
  - # = 8'h12, submit word
  - C = 8'h21, game end
  - D = 8'h11, backspace
- Letter code = group base + tap_count (+32 if LOWERCASE). Group size is 4 for keys 7 and 9, else 3.
- FSM states are IDLE and PEND. Registered pulses make a separate commit state unnecessary.
- IDLE + letter key: latch key, tap_count=0, preview = first letter, go to PEND, timer=0.
- PEND + same key:
  - tap_count+1, preview updated, timer=0.
  - At the last letter: WRAP=1 sets tap_count=0; WRAP=0 holds tap_count.
- PEND + different letter key:
  - data <= old preview, ready pulse.
  - New key latched, tap_count=0, preview = its first letter, stays in PEND, timer=0.
- PEND + *: data <= preview, ready pulse, preview=0, tap_count=0, go to IDLE. IDLE + *: ignored.
- 0 (clear): drop the pending letter, preview=0, tap_count=0, go to IDLE, no ready. In IDLE: no effect.
- D (backspace):
  - In PEND: same as clear, no backspace pulse.
  - In IDLE: backspace pulse.
- # (submit word):
  - In PEND: data <= preview, ready and toggle_state pulse in the same cycle, go to IDLE.
  - In IDLE: toggle_state only.
- C (game end): game_end pulse, pending dropped, data=0, preview=0, go to IDLE, no ready.
- Timeout:
  - In PEND without an event, the timer increments each cycle.
  - In the cycle the timer equals TIMEOUT_CYCLES-1, behaves as *. ready rises exactly TIMEOUT_CYCLES edges after the edge that last updated preview.
  - The timer is held at 0 in IDLE.
- A key event in the same cycle as the timeout terminal count takes priority; the timeout is not applied. A different-letter event commits anyway.
- data holds its value until the next commit or game end.
- nRst asserted mid-PEND: immediate return to reset values, no commit, no pulses.

Test Plan:
- Key 2 strobed 3x, then * -> preview 8'h41, 8'h42, 8'h43; one-cycle ready with data=8'h43; then pending=0, preview=0.
- Key 7 strobed 5x -> WRAP=1: preview P,Q,R,S,P (8'h50, 8'h51, 8'h52, 8'h53, 8'h50). WRAP=0: P,Q,R,S,S. LOWERCASE=1, WRAP=1: 8'h70 … 8'h73, 8'h70.
- Key 2 then key 3 -> ready with data=8'h41 in the cycle preview becomes 8'h44; pending stays 1.
- TIMEOUT_CYCLES=16, key 5 once -> ready with data=8'h4A exactly 16 edges after preview=8'h4A. Same setup with key 5 re-strobed on terminal count -> no ready, preview=8'h4B.
- Pending 'M' (key 6) then # -> ready and toggle_state in the same cycle, data=8'h4D. Then D -> backspace pulse. Then C -> game_end pulse, data=0. Then keys 1/A/B, or 8'h8C with strobe -> no output change.
- Key 9 twice (preview 8'h58), nRst low for 1 cycle -> all outputs 0, no ready. Next key 2 -> preview 8'h41 with tap_count=0.

Source files
------------

// File: rtl/keypad_multitap_if.sv
// Keypad encoder bus: key strobe/code in from the scanner, committed letters,
// live preview and control pulses out to the message/transmit logic.
interface keypad_multitap_if;
    logic       strobe;
    logic [7:0] cur_key;
    logic       ready;
    logic [7:0] data;
    logic [7:0] preview;
    logic       pending;
    logic [1:0] tap_count;
    logic       toggle_state;
    logic       game_end;
    logic       backspace;

    // Scanner / stimulus side
    modport master (
        output strobe, cur_key,
        input  ready, data, preview, pending, tap_count,
        input  toggle_state, game_end, backspace
    );

    // Encoder side
    modport slave (
        input  strobe, cur_key,
        output ready, data, preview, pending, tap_count,
        output toggle_state, game_end, backspace
    );
endinterface

// File: rtl/keypad_multitap.sv
// Multi-tap keypad letter encoder. Repeated taps of one key cycle through its
// letter group; the pending letter is committed by *, #, a different letter
// key or an idle timeout. Every output comes straight from a flop.
module keypad_multitap #(
    parameter int TIMEOUT_CYCLES = 12_000_000,
    parameter int WRAP           = 1,
    parameter int LOWERCASE      = 0
) (
    input  logic               clk,
    input  logic               nRst,
    keypad_multitap_if.slave   kp
);
    localparam int         TIMER_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] CASE_OFF = (LOWERCASE != 0) ? 8'd32 : 8'd0;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, PEND} state_t;

    state_t             state_q, state_d;
    logic [7:0]         key_q, key_d;
    logic [7:0]         base_q, base_d;
    logic [1:0]         last_q, last_d;
    logic [1:0]         tap_q, tap_d;
    logic [7:0]         preview_q, preview_d;
    logic [7:0]         data_q, data_d;
    logic               ready_q, ready_d;
    logic               toggle_q, toggle_d;
    logic               game_end_q, game_end_d;
    logic               backspace_q, backspace_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    // Key event decode; base is the uppercase first letter, last is group size - 1
    logic       ev_letter, ev_star, ev_clear, ev_hash, ev_end, ev_bksp;
    logic [7:0] new_base;
    logic [1:0] new_last;

    // Decode one-hot row/column code into a key event (only when strobed)
    always_comb begin
        ev_letter = 1'b0;
        ev_star   = 1'b0;
        ev_clear  = 1'b0;
        ev_hash   = 1'b0;
        ev_end    = 1'b0;
        ev_bksp   = 1'b0;
        new_base  = 8'h00;
        new_last  = 2'd2;
        if (kp.strobe) begin
            case (kp.cur_key)
                8'h84: begin ev_letter = 1'b1; new_base = 8'h41; end
                8'h82: begin ev_letter = 1'b1; new_base = 8'h44; end
                8'h48: begin ev_letter = 1'b1; new_base = 8'h47; end
                8'h44: begin ev_letter = 1'b1; new_base = 8'h4A; end
                8'h42: begin ev_letter = 1'b1; new_base = 8'h4D; end
                8'h28: begin ev_letter = 1'b1; new_base = 8'h50; new_last = 2'd3; end
                8'h24: begin ev_letter = 1'b1; new_base = 8'h54; end
                8'h22: begin ev_letter = 1'b1; new_base = 8'h57; new_last = 2'd3; end
                8'h18: ev_star  = 1'b1;
                8'h14: ev_clear = 1'b1;
                8'h12: ev_hash  = 1'b1;
                8'h21: ev_end   = 1'b1;
                8'h11: ev_bksp  = 1'b1;
                default: ;
            endcase
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        base_d      = base_q;
        last_d      = last_q;
        tap_d       = tap_q;
        preview_d   = preview_q;
        data_d      = data_q;
        ready_d     = 1'b0;
        toggle_d    = 1'b0;
        game_end_d  = 1'b0;
        backspace_d = 1'b0;
        timer_d     = timer_q + TIMER_W'(1);

        if (ev_letter) begin
            if (state_q == PEND && kp.cur_key == key_q) begin
                if (tap_q == last_q)
                    tap_d = (WRAP != 0) ? 2'd0 : tap_q;
                else
                    tap_d = tap_q + 2'd1;
                preview_d = base_q + {6'd0, tap_d} + CASE_OFF;
            end else begin
                // A different letter key commits whatever was pending first
                if (state_q == PEND) begin
                    data_d  = preview_q;
                    ready_d = 1'b1;
                end
                key_d     = kp.cur_key;
                base_d    = new_base;
                last_d    = new_last;
                tap_d     = 2'd0;
                preview_d = new_base + CASE_OFF;
            end
            state_d = PEND;
            timer_d = '0;
        end else if (ev_star || ev_hash) begin
            if (state_q == PEND) begin
                data_d  = preview_q;
                ready_d = 1'b1;
            end
            toggle_d  = ev_hash;
            preview_d = 8'h00;
            tap_d     = 2'd0;
            state_d   = IDLE;
        end else if (ev_clear || ev_bksp) begin
            // Backspace on a pending letter only discards it; in IDLE it
            // asks downstream to delete the previous committed letter
            backspace_d = ev_bksp && (state_q == IDLE);
            preview_d   = 8'h00;
            tap_d       = 2'd0;
            state_d     = IDLE;
        end else if (ev_end) begin
            game_end_d = 1'b1;
            data_d     = 8'h00;
            preview_d  = 8'h00;
            tap_d      = 2'd0;
            state_d    = IDLE;
        end else if (state_q == PEND && timer_q == TIMER_LAST) begin
            data_d    = preview_q;
            ready_d   = 1'b1;
            preview_d = 8'h00;
            tap_d     = 2'd0;
            state_d   = IDLE;
        end

        if (state_d == IDLE)
            timer_d = '0;
    end

    // State and output registers
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= IDLE;
            key_q       <= 8'h00;
            base_q      <= 8'h00;
            last_q      <= 2'd0;
            tap_q       <= 2'd0;
            preview_q   <= 8'h00;
            data_q      <= 8'h00;
            ready_q     <= 1'b0;
            toggle_q    <= 1'b0;
            game_end_q  <= 1'b0;
            backspace_q <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            base_q      <= base_d;
            last_q      <= last_d;
            tap_q       <= tap_d;
            preview_q   <= preview_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            toggle_q    <= toggle_d;
            game_end_q  <= game_end_d;
            backspace_q <= backspace_d;
            timer_q     <= timer_d;
        end
    end

    assign kp.ready        = ready_q;
    assign kp.data         = data_q;
    assign kp.preview      = preview_q;
    assign kp.pending      = (state_q == PEND);
    assign kp.tap_count    = tap_q;
    assign kp.toggle_state = toggle_q;
    assign kp.game_end     = game_end_q;
    assign kp.backspace    = backspace_q;
endmodule

// File: tb/tb_keypad_multitap.sv
// Directed bench: dut1 (wrap, uppercase) is fully checked with a committed-letter
// scoreboard; dut2 (saturate, lowercase) sees the same stimulus and is checked
// on the group-boundary behaviour.
module tb_keypad_multitap;
    localparam int T = 16;

    logic clk  = 1'b0;
    logic nRst = 1'b0;
    always #5 clk = ~clk;

    keypad_multitap_if kp1 ();
    keypad_multitap_if kp2 ();

    keypad_multitap #(.TIMEOUT_CYCLES(T), .WRAP(1), .LOWERCASE(0)) dut1 (
        .clk(clk), .nRst(nRst), .kp(kp1.slave));
    keypad_multitap #(.TIMEOUT_CYCLES(T), .WRAP(0), .LOWERCASE(1)) dut2 (
        .clk(clk), .nRst(nRst), .kp(kp2.slave));

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [22:0] snap1();
        return {kp1.ready, kp1.data, kp1.preview, kp1.pending, kp1.tap_count,
                kp1.toggle_state, kp1.game_end, kp1.backspace};
    endfunction

    task automatic press(input logic [7:0] k);
        @(posedge clk); #1;
        kp1.strobe = 1'b1; kp1.cur_key = k;
        kp2.strobe = 1'b1; kp2.cur_key = k;
        @(posedge clk); #1;
        kp1.strobe = 1'b0; kp1.cur_key = 8'h00;
        kp2.strobe = 1'b0; kp2.cur_key = 8'h00;
        $display("press key=%h preview=%h tap=%0d pending=%0d ready=%0d data=%h",
                 k, kp1.preview, kp1.tap_count, kp1.pending, kp1.ready, kp1.data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Scoreboard: every ready pulse on dut1 must match the next expected letter
    always @(negedge clk) begin
        if (kp1.ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ready", {24'd0, kp1.data}, 32'h1FF);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("commit_data", {24'd0, kp1.data}, {24'd0, e});
            end
        end
    end

    logic [7:0] p7_wrap [5];
    logic [7:0] p7_sat  [5];

    initial begin
        p7_wrap = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h50};
        p7_sat  = '{8'h70, 8'h71, 8'h72, 8'h73, 8'h73};
        kp1.strobe = 1'b0; kp1.cur_key = 8'h00;
        kp2.strobe = 1'b0; kp2.cur_key = 8'h00;

        // Reset state
        idle(3);
        chk("reset_outputs", {9'd0, snap1()}, 32'd0);
        nRst = 1'b1;
        idle(2);
        chk("after_reset_outputs", {9'd0, snap1()}, 32'd0);

        // Key 2 three times then *
        press(8'h84); chk("k2_prev1", kp1.preview, 8'h41); chk("k2_tap1", kp1.tap_count, 2'd0);
        chk("k2_pending", kp1.pending, 1'b1);
        press(8'h84); chk("k2_prev2", kp1.preview, 8'h42); chk("k2_tap2", kp1.tap_count, 2'd1);
        press(8'h84); chk("k2_prev3", kp1.preview, 8'h43); chk("k2_tap3", kp1.tap_count, 2'd2);
        exp_q.push_back(8'h43);
        press(8'h18);
        chk("star_ready", kp1.ready, 1'b1); chk("star_data", kp1.data, 8'h43);
        chk("star_pending", kp1.pending, 1'b0); chk("star_preview", kp1.preview, 8'h00);
        idle(1);
        chk("star_ready_pulse_end", kp1.ready, 1'b0); chk("data_hold", kp1.data, 8'h43);

        // IDLE + * is ignored
        press(8'h18);
        chk("idle_star_noop", kp1.ready, 1'b0);

        // Key 7 five times: wrap vs saturate/lowercase
        for (int i = 0; i < 5; i++) begin
            press(8'h28);
            chk("k7_wrap_prev", kp1.preview, p7_wrap[i]);
            chk("k7_sat_lc_prev", kp2.preview, p7_sat[i]);
        end
        press(8'h14);
        chk("clear_pending", kp1.pending, 1'b0); chk("clear_preview", kp1.preview, 8'h00);
        chk("clear_tap", kp1.tap_count, 2'd0);

        // Key 2 then key 3 commits 'A' while a new letter becomes pending
        press(8'h84);
        exp_q.push_back(8'h41);
        press(8'h82);
        chk("newkey_ready", kp1.ready, 1'b1); chk("newkey_data", kp1.data, 8'h41);
        chk("newkey_prev", kp1.preview, 8'h44); chk("newkey_pending", kp1.pending, 1'b1);
        press(8'h14);

        // Timeout auto-commit exactly T edges after preview update
        press(8'h44); chk("to_prev", kp1.preview, 8'h4A);
        exp_q.push_back(8'h4A);
        for (int i = 1; i < T; i++) begin
            @(posedge clk); #1;
            chk("to_no_early_ready", kp1.ready, 1'b0);
        end
        @(posedge clk); #1;
        chk("to_ready", kp1.ready, 1'b1); chk("to_data", kp1.data, 8'h4A);
        chk("to_pending", kp1.pending, 1'b0);
        $display("timeout commit data=%h", kp1.data);

        // Same key on the terminal-count cycle wins over the timeout
        press(8'h44);
        idle(T - 2);
        press(8'h44);
        chk("tc_no_ready", kp1.ready, 1'b0); chk("tc_prev", kp1.preview, 8'h4B);
        chk("tc_pending", kp1.pending, 1'b1); chk("tc_tap", kp1.tap_count, 2'd1);
        idle(2);
        chk("tc_timer_restarted", kp1.ready, 1'b0);
        press(8'h14);

        // # commits with toggle, then D backspace, then C game end
        press(8'h42);
        exp_q.push_back(8'h4D);
        press(8'h12);
        chk("hash_ready", kp1.ready, 1'b1); chk("hash_toggle", kp1.toggle_state, 1'b1);
        chk("hash_data", kp1.data, 8'h4D); chk("hash_pending", kp1.pending, 1'b0);
        press(8'h12);
        chk("idle_hash_toggle", kp1.toggle_state, 1'b1); chk("idle_hash_ready", kp1.ready, 1'b0);
        press(8'h11);
        chk("idle_bksp", kp1.backspace, 1'b1);
        idle(1);
        chk("bksp_pulse_end", kp1.backspace, 1'b0);
        press(8'h21);
        chk("gameend_pulse", kp1.game_end, 1'b1); chk("gameend_data", kp1.data, 8'h00);
        chk("gameend_ready", kp1.ready, 1'b0);

        // Ignored codes and key without strobe
        press(8'h88); chk("ign_key1", {9'd0, snap1()}, 32'd0);
        press(8'h81); chk("ign_keyA", {9'd0, snap1()}, 32'd0);
        press(8'h41); chk("ign_keyB", {9'd0, snap1()}, 32'd0);
        press(8'h8C); chk("ign_multihot", {9'd0, snap1()}, 32'd0);
        @(posedge clk); #1;
        kp1.cur_key = 8'h84; kp2.cur_key = 8'h84;
        @(posedge clk); #1;
        kp1.cur_key = 8'h00; kp2.cur_key = 8'h00;
        chk("ign_no_strobe", {9'd0, snap1()}, 32'd0);

        // D while pending: discard only, no backspace pulse
        press(8'h24);
        press(8'h11);
        chk("pend_bksp_pulse", kp1.backspace, 1'b0); chk("pend_bksp_pending", kp1.pending, 1'b0);
        chk("pend_bksp_ready", kp1.ready, 1'b0);

        // Asynchronous reset mid-PEND
        press(8'h22); press(8'h22);
        chk("k9_prev", kp1.preview, 8'h58);
        @(posedge clk); #1;
        nRst = 1'b0;
        #1;
        chk("async_reset_outputs", {9'd0, snap1()}, 32'd0);
        @(posedge clk); #1;
        nRst = 1'b1;
        chk("post_reset_outputs", {9'd0, snap1()}, 32'd0);
        press(8'h84);
        chk("post_reset_prev", kp1.preview, 8'h41); chk("post_reset_tap", kp1.tap_count, 2'd0);
        press(8'h14);

        idle(4);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
